pp_luma_pipe: RTL and testbench
===============================

// Module: pp_luma_pipe
//
// PURPOSE
//  Parametrised, pipelined successor to the preprocessing greyscale stage.
//  Converts packed RGB pixels to luma using the shift-add luminosity method:
//    y = (R>>2)+(R>>5)+(R>>6) + (G>>1)+(G>>4)+(G>>5) + (B>>3)
//  Adds selectable passthrough, greyscale and binary-threshold modes,
//  valid/ready backpressure, and a frame-synchronous mode switch. It sits
//  between the capture/FIFO stage and the downstream filter/display path.
//
// PARAMETERS
//  CW     4  bits per colour channel; pixel width is 3*CW ({R,G,B}, R in MSBs)
//  GUARD  4  zero LSBs appended to each channel before shifting (truncation guard)
//
// PORTS
//  i_clk      in   1     system clock; all logic on posedge
//  i_rst      in   1     synchronous reset, active-high
//  i_valid    in   1     input pixel valid
//  o_ready    out  1     block can accept input this cycle
//  i_data     in   3*CW  input pixel {R,G,B}
//  i_sof      in   1     input pixel is first of frame
//  i_mode     in   2     0=passthrough, 1=greyscale, 2=threshold, 3=reserved (as 0)
//  i_thresh   in   CW    threshold for mode 2, sampled with i_mode
//  o_valid    out  1     output pixel valid
//  i_ready    in   1     downstream accepts output this cycle
//  o_data     out  3*CW  output pixel {R,G,B}
//  o_sof      out  1     start-of-frame, aligned with o_data
//
// BEHAVIOUR
//  Reset (i_rst=1 at posedge): o_valid=0, o_data=0, o_sof=0, all stage valids=0,
//    active mode=0 (passthrough), active threshold=0. Reset mid-frame drops
//    in-flight pixels; no output is produced for them.
//  o_ready is combinational: adv = ~o_valid | i_ready; o_ready = adv.
//  Pipeline: 2 register stages (S1, S2=output), global stall on ~adv.
//    Beat accepted when i_valid & o_ready. Latency 2 cycles under no stall.
//    While o_valid & ~i_ready: o_data, o_sof, o_valid held stable; S1 held.
//    Bubbles: stage valid propagates 0; o_data of an invalid beat is don't-care
//    but driven 0.
//  Mode control: on an accepted beat with i_sof=1, latch i_mode/i_thresh into
//    the active registers; that beat and all following use the new mode.
//    Mode changes without i_sof are ignored. Active mode travels with each
//    beat through S1 so a stall never mixes modes within a beat.
//  S1 arithmetic: each channel extended to W=CW+GUARD bits as {c, GUARD'b0};
//    per-channel shift sums computed at W+1 bits; registered.
//  S2 arithmetic: sum = R-term + G-term + B-term at W+2 bits; saturate to
//    2^W-1 if larger (weights total 1.0156); y = sat_sum[W-1:GUARD] (CW bits).
//  Output by mode: 0/3 -> o_data = input pixel unchanged (delayed 2 cycles);
//    1 -> o_data = {y,y,y}; 2 -> o_data = (y >= thresh) ? all ones : all zeros.
//  o_sof = i_sof of the same beat. Simultaneous accept and output each
//    cycle gives full throughput (1 pixel/clk).
//
// TESTING (CW=4, GUARD=4)
//  1. Reset then mode 1 via sof, feed 12'hFFF,12'hF00,12'h0F0,12'h00F ->
//     o_data 12'hFFF,12'h444,12'h888,12'h111 on cycles 2..5, o_sof on first.
//  2. Mode 0 stream 12'h123,12'hABC -> identical values out after 2 cycles.
//  3. Mode 2, thresh=8: 12'h0F0 -> 12'hFFF; 12'hF00 -> 12'h000; 12'h000 -> 12'h000.
//  4. Change i_mode 0->1 mid-frame without i_sof -> output stays passthrough;
//     next beat with i_sof=1 switches to greyscale from that beat.
//  5. Hold i_ready=0 for 5 cycles with continuous input -> o_ready drops after
//     pipeline fills, o_data stable, no pixel lost or duplicated after release.
//  6. Assert i_rst with 2 beats in flight -> next cycle o_valid=0, mode=0;
//     post-reset pixel 12'hF00 emerges as 12'hF00 (passthrough).

Source files
------------

// File: rtl/pp_luma_pipe.sv
// ----------------------------------------------------------------------------
// pp_luma_pipe
//
// Purpose:
//   Two-stage pipelined RGB-to-luma converter with a valid/ready handshake.
//   Luma is built from a shift-add approximation of the luminosity weights:
//     y = (R>>2)+(R>>5)+(R>>6) + (G>>1)+(G>>4)+(G>>5) + (B>>3)
//   Each channel is widened with GUARD zero LSBs before shifting so that the
//   small-weight terms are not truncated to nothing. The output is one of:
//     mode 0/3 : passthrough (input pixel delayed two cycles)
//     mode 1   : greyscale  {y,y,y}
//     mode 2   : binary threshold, all ones when y >= thresh, else all zeros
//   Mode and threshold are only taken on an accepted start-of-frame beat, so
//   a frame is never rendered in a mix of modes.
//
// Ports:
//   i_clk     clock, all logic on rising edge
//   i_rst     synchronous reset, active high
//   i_valid   input pixel valid
//   o_ready   block accepts input this cycle (combinational)
//   i_data    input pixel {R,G,B}, R in the MSBs, CW bits per channel
//   i_sof     input pixel is first of frame
//   i_mode    requested mode, taken only with i_sof on an accepted beat
//   i_thresh  requested threshold for mode 2, taken together with i_mode
//   o_valid   output pixel valid
//   i_ready   downstream accepts output this cycle
//   o_data    output pixel {R,G,B}
//   o_sof     start-of-frame flag travelling with o_data
// ----------------------------------------------------------------------------
module pp_luma_pipe #(
    parameter int CW    = 4,
    parameter int GUARD = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [3*CW-1:0] i_data,
    input  logic            i_sof,
    input  logic [1:0]      i_mode,
    input  logic [CW-1:0]   i_thresh,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [3*CW-1:0] o_data,
    output logic            o_sof
);

    localparam int W = CW + GUARD;
    localparam logic [W+1:0] SUM_MAX = (W+2)'((1 << W) - 1);

    typedef enum logic [1:0] {
        MODE_PASS   = 2'd0,
        MODE_GREY   = 2'd1,
        MODE_THRESH = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    // ------------------------------------------------------------------
    // Handshake: the whole pipe advances together unless the output
    // register holds a beat the downstream is refusing.
    // ------------------------------------------------------------------
    logic w_adv;
    logic w_accept;

    assign w_adv    = ~o_valid | i_ready;
    assign o_ready  = w_adv;
    assign w_accept = i_valid & w_adv;

    // ------------------------------------------------------------------
    // Active mode/threshold and the mode that applies to the incoming beat
    // ------------------------------------------------------------------
    mode_e         r_mode;
    logic [CW-1:0] r_thresh;
    mode_e         w_beat_mode;
    logic [CW-1:0] w_beat_thresh;

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_beat_mode   = r_mode;
        w_beat_thresh = r_thresh;
        // A start-of-frame beat already uses the mode it brings with it.
        if (i_sof) begin
            w_beat_mode   = mode_e'(i_mode);
            w_beat_thresh = i_thresh;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 arithmetic: guard-extended channels and per-channel sums
    // ------------------------------------------------------------------
    logic [W-1:0] w_r_ext;
    logic [W-1:0] w_g_ext;
    logic [W-1:0] w_b_ext;
    logic [W:0]   w_r_term;
    logic [W:0]   w_g_term;
    logic [W:0]   w_b_term;

    assign w_r_ext = {i_data[3*CW-1:2*CW], {GUARD{1'b0}}};
    assign w_g_ext = {i_data[2*CW-1:CW],   {GUARD{1'b0}}};
    assign w_b_ext = {i_data[CW-1:0],      {GUARD{1'b0}}};

    assign w_r_term = {1'b0, w_r_ext >> 2} + {1'b0, w_r_ext >> 5} + {1'b0, w_r_ext >> 6};
    assign w_g_term = {1'b0, w_g_ext >> 1} + {1'b0, w_g_ext >> 4} + {1'b0, w_g_ext >> 5};
    assign w_b_term = {1'b0, w_b_ext >> 3};

    logic            r_s1_valid;
    logic            r_s1_sof;
    logic [3*CW-1:0] r_s1_data;
    mode_e           r_s1_mode;
    logic [CW-1:0]   r_s1_thresh;
    logic [W:0]      r_s1_r;
    logic [W:0]      r_s1_g;
    logic [W:0]      r_s1_b;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mode      <= MODE_PASS;
            r_thresh    <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_sof    <= 1'b0;
            r_s1_data   <= '0;
            r_s1_mode   <= MODE_PASS;
            r_s1_thresh <= '0;
            r_s1_r      <= '0;
            r_s1_g      <= '0;
            r_s1_b      <= '0;
        end else begin
            if (w_accept && i_sof) begin
                r_mode   <= mode_e'(i_mode);
                r_thresh <= i_thresh;
            end
            if (w_adv) begin
                r_s1_valid  <= i_valid;
                r_s1_sof    <= i_sof;
                r_s1_data   <= i_data;
                r_s1_mode   <= w_beat_mode;
                r_s1_thresh <= w_beat_thresh;
                r_s1_r      <= w_r_term;
                r_s1_g      <= w_g_term;
                r_s1_b      <= w_b_term;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 arithmetic: total, saturation, output selection
    // ------------------------------------------------------------------
    logic [W+1:0]    w_sum;
    logic [CW-1:0]   w_y;
    logic            w_ge;
    logic [3*CW-1:0] w_out;

    assign w_sum = {1'b0, r_s1_r} + {1'b0, r_s1_g} + {1'b0, r_s1_b};
    // The weights add up to slightly more than 1.0, so the total can exceed
    // the W-bit range; saturating there makes y all ones.
    assign w_y   = (w_sum > SUM_MAX) ? '1 : CW'(w_sum >> GUARD);
    assign w_ge  = (w_y >= r_s1_thresh);

    always_comb begin
        w_out = r_s1_data;
        case (r_s1_mode)
            MODE_GREY:   w_out = {w_y, w_y, w_y};
            MODE_THRESH: w_out = {(3*CW){w_ge}};
            default:     w_out = r_s1_data;
        endcase
    end

    logic            r_s2_valid;
    logic            r_s2_sof;
    logic [3*CW-1:0] r_s2_data;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s2_valid <= 1'b0;
            r_s2_sof   <= 1'b0;
            r_s2_data  <= '0;
        end else if (w_adv) begin
            r_s2_valid <= r_s1_valid;
            r_s2_sof   <= r_s1_valid & r_s1_sof;
            // Bubbles leave the output at zero rather than stale data.
            r_s2_data  <= r_s1_valid ? w_out : '0;
        end
    end

    assign o_valid = r_s2_valid;
    assign o_sof   = r_s2_sof;
    assign o_data  = r_s2_data;

endmodule

// File: tb/tb_pp_luma_pipe.sv
// ----------------------------------------------------------------------------
// tb_pp_luma_pipe
//
// Directed bench for pp_luma_pipe with CW=4, GUARD=4. Inputs change 1 time
// unit after the rising edge; outputs are observed on the falling edge. A
// monitor records every transferred output beat as {sof, data}, and each
// scenario task compares that record against hand-computed values.
// ----------------------------------------------------------------------------
module tb_pp_luma_pipe;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [11:0] i_data;
    logic        i_sof;
    logic [1:0]  i_mode;
    logic [3:0]  i_thresh;
    logic        o_valid;
    logic        i_ready;
    logic [11:0] o_data;
    logic        o_sof;

    int checks = 0;
    int errors = 0;

    logic [12:0] got_q[$];
    logic [12:0] exp_q[$];

    pp_luma_pipe #(.CW(4), .GUARD(4)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_data   (i_data),
        .i_sof    (i_sof),
        .i_mode   (i_mode),
        .i_thresh (i_thresh),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_data   (o_data),
        .o_sof    (o_sof)
    );

    always #5 i_clk = ~i_clk;

    // Output monitor: a beat transfers at the next rising edge when valid and
    // ready are both high on the preceding falling edge.
    always @(negedge i_clk) begin
        if (!i_rst && o_valid && i_ready)
            got_q.push_back({o_sof, o_data});
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got running required finished");
        $fatal(1, "watchdog");
    end

    // Present one beat and hold it until it is accepted (bounded wait).
    task automatic push_beat(input logic [11:0] data, input logic sof,
                             input logic [1:0] mode, input logic [3:0] thresh);
        bit accepted = 1'b0;
        i_valid  = 1'b1;
        i_data   = data;
        i_sof    = sof;
        i_mode   = mode;
        i_thresh = thresh;
        for (int n = 0; n < 50 && !accepted; n++) begin
            @(negedge i_clk);
            accepted = o_ready;
            @(posedge i_clk);
            #1;
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got o_ready=0 required 1 data=%h", data);
        end
        i_valid = 1'b0;
        i_sof   = 1'b0;
    endtask

    task automatic drain();
        repeat (4) @(posedge i_clk);
        #1;
    endtask

    task automatic compare_nothing_placeholder_free(); endtask

    task automatic test_reset();
        i_rst    = 1'b1;
        i_valid  = 1'b0;
        i_data   = '0;
        i_sof    = 1'b0;
        i_mode   = 2'd0;
        i_thresh = '0;
        i_ready  = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b0 || o_data !== 12'h000 || o_sof !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b d=%h s=%b required v=0 d=000 s=0",
                     o_valid, o_data, o_sof);
        end
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b required 1", o_ready);
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_greyscale();
        got_q.delete();
        push_beat(12'hFFF, 1'b1, 2'd1, 4'd0);
        push_beat(12'hF00, 1'b0, 2'd1, 4'd0);
        push_beat(12'h0F0, 1'b0, 2'd1, 4'd0);
        push_beat(12'h00F, 1'b0, 2'd1, 4'd0);
        drain();
        exp_q = '{13'h1FFF, 13'h0444, 13'h0888, 13'h0111};
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL grey_count got %0d required %0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL grey_beat%0d got %h required %h", k, got_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_passthrough_latency();
        got_q.delete();
        i_valid = 1'b1; i_data = 12'h123; i_sof = 1'b1; i_mode = 2'd0; i_thresh = 4'd0;
        @(negedge i_clk);
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL pass_accept got o_ready=%b required 1", o_ready);
        end
        @(posedge i_clk);
        #1;
        i_data = 12'hABC; i_sof = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL pass_latency1 got o_valid=%b required 0", o_valid);
        end
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b1 || o_data !== 12'h123 || o_sof !== 1'b1) begin
            errors++;
            $display("FAIL pass_beat0 got v=%b d=%h s=%b required v=1 d=123 s=1",
                     o_valid, o_data, o_sof);
        end
        @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b1 || o_data !== 12'hABC || o_sof !== 1'b0) begin
            errors++;
            $display("FAIL pass_beat1 got v=%b d=%h s=%b required v=1 d=ABC s=0",
                     o_valid, o_data, o_sof);
        end
        @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b0 || o_data !== 12'h000) begin
            errors++;
            $display("FAIL pass_bubble got v=%b d=%h required v=0 d=000", o_valid, o_data);
        end
        @(posedge i_clk);
        #1;
        // Reserved mode behaves as passthrough.
        got_q.delete();
        push_beat(12'h5A5, 1'b1, 2'd3, 4'd0);
        push_beat(12'hF00, 1'b0, 2'd3, 4'd0);
        drain();
        exp_q = '{13'h15A5, 13'h0F00};
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rsvd_count got %0d required %0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL rsvd_beat%0d got %h required %h", k, got_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_threshold();
        got_q.delete();
        push_beat(12'h0F0, 1'b1, 2'd2, 4'd8);   // y = 8, equal to threshold
        push_beat(12'hF00, 1'b0, 2'd2, 4'd8);   // y = 4
        push_beat(12'h000, 1'b0, 2'd2, 4'd8);   // y = 0
        push_beat(12'hFFF, 1'b0, 2'd2, 4'd8);   // y = 15
        drain();
        exp_q = '{13'h1FFF, 13'h0000, 13'h0000, 13'h0FFF};
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL thresh_count got %0d required %0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL thresh_beat%0d got %h required %h", k, got_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_mode_no_sof();
        got_q.delete();
        push_beat(12'h0F0, 1'b1, 2'd0, 4'd0);   // frame in passthrough
        push_beat(12'h0F0, 1'b0, 2'd1, 4'd0);   // mode change ignored
        push_beat(12'h0F0, 1'b1, 2'd1, 4'd0);   // sof switches to greyscale
        push_beat(12'hF00, 1'b0, 2'd0, 4'd0);   // mode change ignored
        drain();
        exp_q = '{13'h10F0, 13'h00F0, 13'h1888, 13'h0444};
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL nosof_count got %0d required %0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL nosof_beat%0d got %h required %h", k, got_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [11:0] pix[6];
        int idx = 0;
        bit  rdy;
        pix = '{12'h101, 12'h102, 12'h103, 12'h104, 12'h105, 12'h106};
        got_q.delete();
        i_ready = 1'b0;
        for (int cyc = 0; cyc < 7; cyc++) begin
            i_valid = 1'b1;
            i_data  = pix[idx];
            i_sof   = (idx == 0);
            i_mode  = 2'd0;
            @(negedge i_clk);
            rdy = o_ready;
            if (cyc >= 2) begin
                checks++;
                if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_data !== 12'h101 || o_sof !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_cyc%0d got r=%b v=%b d=%h s=%b required r=0 v=1 d=101 s=1",
                             cyc, o_ready, o_valid, o_data, o_sof);
                end
            end
            @(posedge i_clk);
            #1;
            if (rdy && idx < 5) idx++;
        end
        checks++;
        if (idx != 2) begin
            errors++;
            $display("FAIL stall_accepted got %0d required 2", idx);
        end
        i_valid = 1'b0;
        i_sof   = 1'b0;
        i_ready = 1'b1;
        for (int k = idx; k < 6; k++)
            push_beat(pix[k], 1'b0, 2'd0, 4'd0);
        drain();
        exp_q = '{13'h1101, 13'h0102, 13'h0103, 13'h0104, 13'h0105, 13'h0106};
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL stall_count got %0d required %0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL stall_beat%0d got %h required %h", k, got_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_reset_midflight();
        push_beat(12'hFFF, 1'b1, 2'd1, 4'd0);
        push_beat(12'hF00, 1'b0, 2'd1, 4'd0);
        // Two greyscale beats in flight: S1 holds F00, output holds FFF.
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        got_q.delete();
        @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b0 || o_data !== 12'h000 || o_sof !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs got v=%b d=%h s=%b required v=0 d=000 s=0",
                     o_valid, o_data, o_sof);
        end
        @(posedge i_clk);
        #1;
        // No sof: the beat must use the reset mode, i.e. passthrough.
        push_beat(12'hF00, 1'b0, 2'd1, 4'd0);
        drain();
        exp_q = '{13'h0F00};
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL midrst_count got %0d required %0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL midrst_beat%0d got %h required %h", k, got_q[k], exp_q[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_greyscale();
        test_passthrough_latency();
        test_threshold();
        test_mode_no_sof();
        test_backpressure();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
